// File: rtl/booth_pp_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : booth_pp_accumulator
// Purpose  : Sequential radix-4 Booth partial-product decoder/accumulator.
//            Consumes one Booth digit (one/two/neg) per accepted handshake,
//            selects 0/A/2A from the latched multiplicand, negates it when
//            neg is set, weights it by 4^idx and accumulates into a
//            2*WIDTH-bit two's complement product.
// Ports    : clk, rst_n          - rising-edge clock, async active-low reset
//            start, multiplicand - begin a product, A latched on acceptance
//            digit_valid/ready   - digit handshake (ready only while ACCUM)
//            one, two, neg       - Booth digit magnitude/sign
//            product             - A*B, updated only when done pulses
//            done                - one-cycle completion pulse
//            busy                - high while accumulating
//            err                 - sticky illegal-digit (one&two) flag
// Revision : 1.0 - initial release
// ============================================================================
module booth_pp_accumulator #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic                 digit_valid,
    output logic                 digit_ready,
    input  logic                 one,
    input  logic                 two,
    input  logic                 neg,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done,
    output logic                 busy,
    output logic                 err
);

    localparam int DIGITS = WIDTH / 2;
    localparam int PW     = 2 * WIDTH;
    localparam int IDXW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [PW-1:0]    a_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    product_q;
    logic [IDXW-1:0]  idx_q;
    logic             done_q;
    logic             err_q;

    logic             w_illegal;
    logic             w_accept;
    logic [PW-1:0]    w_a_ext;
    logic [PW-1:0]    w_mag;
    logic [PW-1:0]    w_pp;
    logic [PW-1:0]    w_pp_shift;
    logic [PW-1:0]    acc_d;

    // ------------------------------------------------------------------------
    // Partial-product datapath
    // ------------------------------------------------------------------------
    assign w_a_ext   = {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
    assign w_illegal = one & two;
    assign w_accept  = digit_valid && (state_q == S_ACCUM);

    // An illegal one&two digit contributes nothing; it only raises err.
    always_comb begin
        w_mag = '0;
        if (!w_illegal) begin
            if (one) begin
                w_mag = a_q;
            end else if (two) begin
                w_mag = a_q << 1;
            end
        end
    end

    // Negating a zero magnitude yields zero, so the 000/111 windows add 0.
    assign w_pp       = neg ? (-w_mag) : w_mag;
    // Each radix-4 digit carries weight 4^idx: shift by 2*idx.
    assign w_pp_shift = w_pp << {idx_q, 1'b0};
    assign acc_d      = acc_q + w_pp_shift;

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= w_a_ext;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    // start is deliberately ignored while accumulating.
                    if (w_accept) begin
                        acc_q <= acc_d;
                        idx_q <= idx_q + 1'b1;
                        if (w_illegal) begin
                            err_q <= 1'b1;
                        end
                        if (idx_q == LAST_IDX) begin
                            product_q <= acc_d;
                            done_q    <= 1'b1;
                            state_q   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // A start coinciding with done launches the next product
                    // directly; product holds until that product completes.
                    if (start) begin
                        a_q     <= w_a_ext;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= S_ACCUM;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign digit_ready = (state_q == S_ACCUM);
    assign busy        = (state_q == S_ACCUM);
    assign done        = done_q;
    assign product     = product_q;
    assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_pp_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_pp_accumulator
// Purpose  : Self-checking bench for booth_pp_accumulator. Expected products
//            are queued when an operation is launched and compared when the
//            DUT pulses done. Digits come from a radix-4 Booth encoder model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_booth_pp_accumulator;

    typedef logic [3:0][2:0] dig_t;   // per digit {one, two, neg}, digit 0 first
    typedef struct packed {
        logic [15:0] p;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  multiplicand = '0;
    logic        digit_valid = 1'b0;
    logic        one = 1'b0;
    logic        two = 1'b0;
    logic        neg = 1'b0;
    logic        digit_ready;
    logic [15:0] product;
    logic        done;
    logic        busy;
    logic        err;

    int          errors = 0;
    int          checks = 0;
    longint      cyc = 0;
    exp_t        sb[$];
    logic        prev_done = 1'b0;
    logic [15:0] last_product = '0;

    booth_pp_accumulator #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .digit_valid  (digit_valid),
        .digit_ready  (digit_ready),
        .one          (one),
        .two          (two),
        .neg          (neg),
        .product      (product),
        .done         (done),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Radix-4 Booth encoder model: window k = (b[2k+1], b[2k], b[2k-1]).
    function automatic dig_t enc(input logic [7:0] b);
        logic [8:0] x;
        logic [2:0] w;
        dig_t       d;
        x = {b, 1'b0};
        for (int k = 0; k < 4; k++) begin
            w = x[2*k+2 -: 3];
            d[k] = {w[1] ^ w[0],
                    (w[2] & ~w[1] & ~w[0]) | (~w[2] & w[1] & w[0]),
                    w[2]};
        end
        return d;
    endfunction

    function automatic logic [15:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    // Scoreboard monitor: compares at every done pulse, and checks that
    // product never moves without done.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done    = 1'b0;
            last_product = product;
        end else begin
            if (done) begin
                checks++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_pulse_width: done high two cycles in a row at cycle %0d", cyc);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got product=%h with empty scoreboard", product);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (product !== e.p) begin
                        errors++;
                        $display("FAIL product: got %h expected %h", product, e.p);
                    end
                    checks++;
                    if (err !== e.e) begin
                        errors++;
                        $display("FAIL err_at_done: got %b expected %b", err, e.e);
                    end
                end
            end else begin
                checks++;
                if (product !== last_product) begin
                    errors++;
                    $display("FAIL product_stable: got %h expected %h (no done)", product, last_product);
                end
            end
            prev_done    = done;
            last_product = product;
        end
    end

    // Present four digits; gap idle cycles (with junk digit lines) between them.
    task automatic feed_digits(input dig_t dg, input int gap, input bit junk_start);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                repeat (gap) begin
                    digit_valid = 1'b0;
                    {one, two, neg} = 3'($urandom);
                    @(posedge clk); #1;
                end
            end
            start = junk_start && (k < 3);
            multiplicand = 8'($urandom);
            {one, two, neg} = dg[k];
            digit_valid = 1'b1;
            @(posedge clk); #1;
            digit_valid = 1'b0;
            start = 1'b0;
        end
    endtask

    // Launch one product; returns the cycle stamp of the start edge.
    task automatic drive_op(input logic [7:0] a, input dig_t dg, input int gap,
                            input exp_t e, input bit junk_start, output longint s_cyc);
        sb.push_back(e);
        start = 1'b1;
        multiplicand = a;
        @(posedge clk); #1;
        start = 1'b0;
        s_cyc = cyc;
        feed_digits(dg, gap, junk_start);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({product, done, busy, err, digit_ready} !== 20'h0) begin
            errors++;
            $display("FAIL reset_state: got prod=%h done=%b busy=%b err=%b rdy=%b expected all 0",
                     product, done, busy, err, digit_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        longint s;
        // Digits presented while IDLE must be refused and dropped.
        digit_valid = 1'b1;
        {one, two, neg} = 3'b100;
        @(negedge clk);
        checks++;
        if (digit_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got %b expected 0", digit_ready);
        end
        @(posedge clk); #1;
        digit_valid = 1'b0;

        drive_op(8'd3, enc(8'hFE), 0, '{p: 16'hFFFA, e: 1'b0}, 1'b0, s);
        checks++;
        if (done !== 1'b1 || (cyc - s) != 4) begin
            errors++;
            $display("FAIL latency_3x-2: got done=%b edges=%0d expected done=1 edges=4", done, cyc - s);
        end
        @(posedge clk); #1;
        drive_op(8'h80, enc(8'h80), 0, '{p: 16'h4000, e: 1'b0}, 1'b0, s);
        @(posedge clk); #1;
        drive_op(8'd127, enc(8'd127), 0, '{p: 16'h3F01, e: 1'b0}, 1'b0, s);
        @(posedge clk); #1;
    endtask

    task automatic test_gaps();
        longint s;
        drive_op(8'd127, enc(8'd127), 3, '{p: 16'h3F01, e: 1'b0}, 1'b0, s);
        checks++;
        if (done !== 1'b1 || (cyc - s) != 13) begin
            errors++;
            $display("FAIL gap_latency: got done=%b edges=%0d expected done=1 edges=13", done, cyc - s);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_err();
        longint s;
        dig_t d;
        d = '0;
        d[1] = 3'b110;
        drive_op(8'd5, d, 0, '{p: 16'h0000, e: 1'b1}, 1'b0, s);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 1", err);
        end
        // Back-to-back start clears err; monitor expects err=0 at its done.
        drive_op(8'd3, enc(8'hFE), 0, '{p: 16'hFFFA, e: 1'b0}, 1'b0, s);
        @(posedge clk); #1;
    endtask

    task automatic test_start_busy();
        longint s;
        // start held with a junk multiplicand during ACCUM must be ignored.
        drive_op(8'hD6, enc(8'h5B), 1, '{p: mul(8'hD6, 8'h5B), e: 1'b0}, 1'b1, s);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        longint s;
        drive_op(8'd3, enc(8'hFE), 0, '{p: 16'hFFFA, e: 1'b0}, 1'b0, s);
        sb.push_back('{p: mul(8'h9C, 8'h27), e: 1'b0});
        start = 1'b1;
        multiplicand = 8'h9C;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || product !== 16'hFFFA) begin
            errors++;
            $display("FAIL start_in_done: got busy=%b done=%b prod=%h expected 1 0 fffa",
                     busy, done, product);
        end
        feed_digits(enc(8'h27), 0, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        longint s;
        dig_t d;
        d = enc(8'hFE);
        d[0] = 3'b110;
        start = 1'b1;
        multiplicand = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            {one, two, neg} = d[k];
            digit_valid = 1'b1;
            @(posedge clk); #1;
        end
        digit_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: got busy=%b err=%b expected 1 1", busy, err);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({product, done, busy, err, digit_ready} !== 20'h0) begin
            errors++;
            $display("FAIL async_abort: got prod=%h done=%b busy=%b err=%b rdy=%b expected all 0",
                     product, done, busy, err, digit_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_op(8'd3, enc(8'hFE), 0, '{p: 16'hFFFA, e: 1'b0}, 1'b0, s);
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        longint s;
        logic [7:0] a;
        logic [7:0] b;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            drive_op(a, enc(b), int'($urandom_range(0, 1)), '{p: mul(a, b), e: 1'b0},
                     1'($urandom_range(0, 1)), s);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_gaps();
        test_err();
        test_start_busy();
        test_back_to_back();
        test_abort();
        test_random();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
